// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU arbiter slice: ALU opcode encodings, the
// arbiter FSM state encoding and the arbitration helper used to pick a winner.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam logic [2:0] OP_ZERO = 3'b000;
    localparam logic [2:0] OP_AND  = 3'b001;
    localparam logic [2:0] OP_OR   = 3'b010;
    localparam logic [2:0] OP_XOR  = 3'b011;
    localparam logic [2:0] OP_NOTA = 3'b100;
    localparam logic [2:0] OP_SUB  = 3'b101;
    localparam logic [2:0] OP_ADD  = 3'b110;
    localparam logic [2:0] OP_ONES = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Returns the winning port (0/1). Only meaningful when at least one request
    // is high. With both requesting, round-robin hands the slot to the port that
    // was not granted last; fixed priority always favours port 0.
    function automatic logic pick_winner(input logic req0,
                                         input logic req1,
                                         input logic last,
                                         input logic fixed_prio);
        if (req0 && req1) begin
            return fixed_prio ? 1'b0 : ~last;
        end
        return req1 & ~req0;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// -----------------------------------------------------------------------------
// alu_arbiter_if
// Bundles the two requester ports and the result port of the ALU arbiter.
//   req0/A0/B0/Sel0, req1/A1/B1/Sel1 : requests, operands and opcodes
//   gnt0/gnt1                        : one-cycle grant pulses
//   y/valid/id/ack                   : result, result-valid, owner port, accept
//   zf/cf                            : result flags (only with ALU_ARB_FLAGS_EN)
// Modports: master = clients/consumer side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface alu_arbiter_if #(
    parameter int WIDTH = 8
);
    logic             req0;
    logic [WIDTH-1:0] A0;
    logic [WIDTH-1:0] B0;
    logic [2:0]       Sel0;
    logic             req1;
    logic [WIDTH-1:0] A1;
    logic [WIDTH-1:0] B1;
    logic [2:0]       Sel1;
    logic             gnt0;
    logic             gnt1;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             id;
    logic             ack;
`ifdef ALU_ARB_FLAGS_EN
    logic             zf;
    logic             cf;

    modport master (
        output req0, A0, B0, Sel0, req1, A1, B1, Sel1, ack,
        input  gnt0, gnt1, y, valid, id, zf, cf
    );

    modport slave (
        input  req0, A0, B0, Sel0, req1, A1, B1, Sel1, ack,
        output gnt0, gnt1, y, valid, id, zf, cf
    );
`else
    modport master (
        output req0, A0, B0, Sel0, req1, A1, B1, Sel1, ack,
        input  gnt0, gnt1, y, valid, id
    );

    modport slave (
        input  req0, A0, B0, Sel0, req1, A1, B1, Sel1, ack,
        output gnt0, gnt1, y, valid, id
    );
`endif
endinterface

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational WIDTH-bit ALU shared by both arbiter ports.
//   a, b : operands
//   sel  : opcode (fully decoded, see alu_pkg)
//   y    : result; add/subtract wrap modulo 2^WIDTH
//   cf   : carry-out for ADD, borrow (a < b unsigned) for SUB, 0 otherwise
// -----------------------------------------------------------------------------
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] y,
    output logic             cf
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit on each: the MSB of the sum is the carry, and the MSB of the
    // zero-extended difference is set exactly when a < b (the borrow).
    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        y  = '0;
        cf = 1'b0;
        case (sel)
            OP_ZERO: y = '0;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NOTA: y = ~a;
            OP_SUB: begin
                y  = diff[WIDTH-1:0];
                cf = diff[WIDTH];
            end
            OP_ADD: begin
                y  = sum[WIDTH-1:0];
                cf = sum[WIDTH];
            end
            OP_ONES: y = '1;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
// Shares one combinational ALU (alu_core) between two requesters. The winner's
// operands are latched on grant, executed one cycle later, and the registered
// result is held until acknowledged. One operation in flight at a time.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous reset, active-high
//   bus  : alu_arbiter_if.slave (requests, operands, grants, result, ack)
// Parameters:
//   WIDTH     operand/result width
//   PRIO_MODE 0 = round-robin, 1 = fixed priority with port 0 winning
// Optional feature: define ALU_ARB_FLAGS_EN to add registered zf/cf outputs.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for a request; on any req, grant winner and latch ops
// ST_EXEC | latched operands at the ALU; capture result into y/valid/id
// ST_RESP | result held stable until ack, then back to ST_IDLE
// -----------------------------------------------------------------------------
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRIO_MODE = 0
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    localparam logic FIXED_PRIO = (PRIO_MODE == 1);

    state_t           state_q;
    state_t           state_d;
    logic             grant;
    logic             win;

    // Last granted port; doubles as the owner of the operation in flight.
    // Resets to port 1 so that port 0 wins the first contest.
    logic             last_q;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       sel_q;
    logic             gnt0_q;
    logic             gnt1_q;
    logic [WIDTH-1:0] y_q;
    logic             valid_q;
    logic             id_q;

    logic [WIDTH-1:0] alu_y;
    logic             alu_cf;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_alu_core (
        .a   (a_q),
        .b   (b_q),
        .sel (sel_q),
        .y   (alu_y),
        .cf  (alu_cf)
    );

    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        win     = pick_winner(bus.req0, bus.req1, last_q, FIXED_PRIO);
        case (state_q)
            ST_IDLE: begin
                if (bus.req0 || bus.req1) begin
                    grant   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: state_d = ST_RESP;
            ST_RESP: begin
                // ack drops valid on this edge; the next grant can only come
                // from ST_IDLE one cycle later.
                if (bus.ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            last_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            sel_q   <= OP_ZERO;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            y_q     <= '0;
            valid_q <= 1'b0;
            id_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= grant & ~win;
            gnt1_q  <= grant & win;
            if (grant) begin
                a_q    <= win ? bus.A1 : bus.A0;
                b_q    <= win ? bus.B1 : bus.B0;
                sel_q  <= win ? bus.Sel1 : bus.Sel0;
                last_q <= win;
            end
            if (state_q == ST_EXEC) begin
                y_q     <= alu_y;
                valid_q <= 1'b1;
                id_q    <= last_q;
            end else if (state_q == ST_RESP && bus.ack) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign bus.gnt0  = gnt0_q;
    assign bus.gnt1  = gnt1_q;
    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign bus.id    = id_q;

`ifdef ALU_ARB_FLAGS_EN
    logic zf_q;
    logic cf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zf_q <= 1'b0;
            cf_q <= 1'b0;
        end else if (state_q == ST_EXEC) begin
            zf_q <= (alu_y == '0);
            cf_q <= alu_cf;
        end
    end

    assign bus.zf = zf_q;
    assign bus.cf = cf_q;
`else
    // Carry/borrow has no consumer without the flag outputs.
    logic unused_cf;
    assign unused_cf = alu_cf;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
// Self-checking bench for alu_arbiter: a round-robin instance and a fixed
// priority instance share clk/rst. Expected results are pushed into a queue
// when requests are driven and popped when valid is observed.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_arbiter_if #(.WIDTH(8)) bus ();
    alu_arbiter_if #(.WIDTH(8)) bus_fp ();

    alu_arbiter #(.WIDTH(8), .PRIO_MODE(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    alu_arbiter #(.WIDTH(8), .PRIO_MODE(1)) dut_fp (
        .clk (clk),
        .rst (rst),
        .bus (bus_fp)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [10:0] exp_q[$];      // {cf, zf, id, y}
    logic        model_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required run to complete");
        $fatal(1);
    end

    // Independent reference: returns {cf, y}.
    function automatic logic [8:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] s);
        logic [8:0] r;
        r = 9'h000;
        case (s)
            3'd0: r = 9'h000;
            3'd1: r = {1'b0, a & b};
            3'd2: r = {1'b0, a | b};
            3'd3: r = {1'b0, a ^ b};
            3'd4: r = {1'b0, ~a};
            3'd5: begin r[7:0] = a - b; r[8] = (a < b); end
            3'd6: r = {1'b0, a} + {1'b0, b};
            default: r = {1'b0, 8'hFF};
        endcase
        return r;
    endfunction

    function automatic logic [10:0] expect_entry(input logic pid, input logic [7:0] a,
                                                 input logic [7:0] b, input logic [2:0] s);
        logic [8:0] r;
        r = alu_model(a, b, s);
        return {r[8], (r[7:0] == 8'h00), pid, r[7:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.gnt0 || bus.gnt1) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.valid) begin
                ok = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic ack_it();
        bus.ack = 1'b1;
        step();
        bus.ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        model_last = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.req0 = 1'b1; bus.A0 = 8'h5A; bus.B0 = 8'h0F; bus.Sel0 = OP_ADD;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_cmp++;
            if (bus.gnt0 !== 1'b0 || bus.valid !== 1'b0 || bus.y !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_outputs cycle %0d: gnt0=%b valid=%b y=%h, required gnt0=0 valid=0 y=00",
                         i, bus.gnt0, bus.valid, bus.y);
            end
        end
        n_cmp++;
        if (bus.id !== 1'b0 || bus.gnt1 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_id: id=%b gnt1=%b, required 0 0", bus.id, bus.gnt1);
        end
        bus.req0 = 1'b0;
        rst = 1'b0;
        model_last = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_single_op();
        bit ok;
        logic [10:0] e;
        logic [7:0] tab [8] = '{8'h00, 8'h95, 8'hFF, 8'h6A, 8'h22, 8'h26, 8'h94, 8'hFF};
        bus.A0 = 8'hDD; bus.B0 = 8'hB7; bus.Sel0 = OP_ADD; bus.req0 = 1'b1;
        exp_q.push_back(expect_entry(1'b0, 8'hDD, 8'hB7, OP_ADD));
        wait_gnt(ok);
        n_cmp++;
        if (!ok || bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            n_bad++;
            $display("FAIL single_gnt: gnt0=%b gnt1=%b, required 1 0", bus.gnt0, bus.gnt1);
        end
        bus.req0 = 1'b0;
        model_last = 1'b0;
        step();
        n_cmp++;
        if (bus.valid !== 1'b1) begin
            n_bad++;
            $display("FAIL single_latency: valid=%b one cycle after gnt, required 1", bus.valid);
        end
        e = exp_q.pop_front();
        n_cmp++;
        if (bus.y !== e[7:0] || bus.id !== e[8] || bus.y !== 8'h94) begin
            n_bad++;
            $display("FAIL single_result: y=%h id=%b, required y=%h id=%b", bus.y, bus.id, e[7:0], e[8]);
        end
        ack_it();
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_ack_drop: valid=%b, required 0", bus.valid);
        end
        // Opcode sweep through port 1.
        for (int s = 0; s < 8; s++) begin
            bus.A1 = 8'hDD; bus.B1 = 8'hB7; bus.Sel1 = 3'(s); bus.req1 = 1'b1;
            exp_q.push_back(expect_entry(1'b1, 8'hDD, 8'hB7, 3'(s)));
            wait_gnt(ok);
            bus.req1 = 1'b0;
            model_last = 1'b1;
            n_cmp++;
            if (!ok || bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
                n_bad++;
                $display("FAIL sweep_gnt op %0d: gnt0=%b gnt1=%b, required 0 1", s, bus.gnt0, bus.gnt1);
            end
            wait_valid(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || bus.y !== tab[s] || bus.y !== e[7:0] || bus.id !== 1'b1) begin
                n_bad++;
                $display("FAIL sweep_result op %0d: y=%h id=%b valid=%b, required y=%h id=1",
                         s, bus.y, bus.id, bus.valid, tab[s]);
            end
            ack_it();
        end
    endtask

    task automatic test_contention();
        bit ok;
        logic w;
        logic [10:0] e;
        do_reset();
        bus.A0 = 8'h11; bus.B0 = 8'h22; bus.Sel0 = OP_ADD;
        bus.A1 = 8'h40; bus.B1 = 8'h0F; bus.Sel1 = OP_OR;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = ~model_last;
            exp_q.push_back(w ? expect_entry(1'b1, 8'h40, 8'h0F, OP_OR)
                              : expect_entry(1'b0, 8'h11, 8'h22, OP_ADD));
            wait_gnt(ok);
            model_last = w;
            n_cmp++;
            if (!ok || bus.gnt0 !== ~w || bus.gnt1 !== w || w !== 1'(k % 2)) begin
                n_bad++;
                $display("FAIL rr_order op %0d: gnt0=%b gnt1=%b, required port %0d", k, bus.gnt0, bus.gnt1, k % 2);
            end
            wait_valid(ok);
            e = exp_q.pop_front();
            n_cmp++;
            if (!ok || bus.y !== e[7:0] || bus.id !== e[8]) begin
                n_bad++;
                $display("FAIL rr_result op %0d: y=%h id=%b, required y=%h id=%b", k, bus.y, bus.id, e[7:0], e[8]);
            end
            ack_it();
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
    endtask

    task automatic test_fixed_prio();
        bit ok;
        bus_fp.A0 = 8'h0C; bus_fp.B0 = 8'h0A; bus_fp.Sel0 = OP_XOR;
        bus_fp.A1 = 8'hF0; bus_fp.B1 = 8'h0F; bus_fp.Sel1 = OP_AND;
        bus_fp.req0 = 1'b1; bus_fp.req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(expect_entry(1'b0, 8'h0C, 8'h0A, OP_XOR));
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                step();
                if (bus_fp.gnt0 || bus_fp.gnt1) begin ok = 1'b1; break; end
            end
            n_cmp++;
            if (!ok || bus_fp.gnt0 !== 1'b1 || bus_fp.gnt1 !== 1'b0) begin
                n_bad++;
                $display("FAIL fixed_prio_gnt op %0d: gnt0=%b gnt1=%b, required 1 0", k, bus_fp.gnt0, bus_fp.gnt1);
            end
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (bus_fp.valid) begin ok = 1'b1; break; end
                step();
            end
            n_cmp++;
            if (!ok || bus_fp.y !== exp_q[0][7:0] || bus_fp.id !== exp_q[0][8]) begin
                n_bad++;
                $display("FAIL fixed_prio_result op %0d: y=%h id=%b, required y=%h id=%b",
                         k, bus_fp.y, bus_fp.id, exp_q[0][7:0], exp_q[0][8]);
            end
            void'(exp_q.pop_front());
            bus_fp.ack = 1'b1;
            step();
            bus_fp.ack = 1'b0;
        end
        bus_fp.req0 = 1'b0; bus_fp.req1 = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        logic [7:0] y0;
        logic id0;
        logic [10:0] e;
        bus.A0 = 8'h3C; bus.B0 = 8'h0F; bus.Sel0 = OP_SUB; bus.req0 = 1'b1;
        exp_q.push_back(expect_entry(1'b0, 8'h3C, 8'h0F, OP_SUB));
        wait_gnt(ok);
        bus.req0 = 1'b0;
        model_last = 1'b0;
        n_cmp++;
        if (!ok || bus.gnt0 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_gnt0: gnt0=%b, required 1", bus.gnt0);
        end
        bus.A1 = 8'h81; bus.B1 = 8'h18; bus.Sel1 = OP_XOR; bus.req1 = 1'b1;
        step();
        e = exp_q.pop_front();
        y0 = bus.y;
        id0 = bus.id;
        n_cmp++;
        if (bus.valid !== 1'b1 || bus.y !== e[7:0] || bus.id !== e[8]) begin
            n_bad++;
            $display("FAIL bp_result: valid=%b y=%h id=%b, required valid=1 y=%h id=%b",
                     bus.valid, bus.y, bus.id, e[7:0], e[8]);
        end
        for (int i = 0; i < 10; i++) begin
            step();
            n_cmp++;
            if (bus.valid !== 1'b1 || bus.y !== y0 || bus.id !== id0 || bus.gnt1 !== 1'b0) begin
                n_bad++;
                $display("FAIL bp_hold cycle %0d: valid=%b y=%h id=%b gnt1=%b, required 1 %h %b 0",
                         i, bus.valid, bus.y, bus.id, bus.gnt1, y0, id0);
            end
        end
        exp_q.push_back(expect_entry(1'b1, 8'h81, 8'h18, OP_XOR));
        ack_it();
        n_cmp++;
        if (bus.valid !== 1'b0 || bus.gnt1 !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_ack_cycle: valid=%b gnt1=%b, required 0 0", bus.valid, bus.gnt1);
        end
        step();
        bus.req1 = 1'b0;
        model_last = 1'b1;
        n_cmp++;
        if (bus.gnt1 !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_next_gnt1: gnt1=%b, required 1", bus.gnt1);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || bus.y !== e[7:0] || bus.id !== e[8]) begin
            n_bad++;
            $display("FAIL bp_second_result: y=%h id=%b, required y=%h id=%b", bus.y, bus.id, e[7:0], e[8]);
        end
        ack_it();
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [10:0] e;
        bus.A1 = 8'h07; bus.B1 = 8'h01; bus.Sel1 = OP_ADD; bus.req1 = 1'b1;
        exp_q.push_back(expect_entry(1'b1, 8'h07, 8'h01, OP_ADD));
        wait_gnt(ok);
        bus.req1 = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        exp_q.delete();
        model_last = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (bus.valid !== 1'b0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
                n_bad++;
                $display("FAIL midrst_no_valid cycle %0d: valid=%b gnt0=%b gnt1=%b, required 0 0 0",
                         i, bus.valid, bus.gnt0, bus.gnt1);
            end
            step();
        end
        bus.A0 = 8'hA5; bus.B0 = 8'h00; bus.Sel0 = OP_NOTA;
        bus.A1 = 8'h01; bus.B1 = 8'h01; bus.Sel1 = OP_ONES;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        exp_q.push_back(expect_entry(~model_last, 8'hA5, 8'h00, OP_NOTA));
        wait_gnt(ok);
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        model_last = 1'b0;
        n_cmp++;
        if (!ok || bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
            n_bad++;
            $display("FAIL midrst_first_contest: gnt0=%b gnt1=%b, required 1 0", bus.gnt0, bus.gnt1);
        end
        wait_valid(ok);
        e = exp_q.pop_front();
        n_cmp++;
        if (!ok || bus.y !== e[7:0] || bus.id !== e[8]) begin
            n_bad++;
            $display("FAIL midrst_result: y=%h id=%b, required y=%h id=%b", bus.y, bus.id, e[7:0], e[8]);
        end
        ack_it();
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic w;
        int m;
        logic [10:0] e;
        logic [7:0] a0, b0, a1, b1;
        logic [2:0] s0, s1;
        bus.ack = 1'b1;
        for (int k = 0; k < 8; k++) begin
            m = $urandom_range(1, 3);
            a0 = 8'($urandom); b0 = 8'($urandom); s0 = 3'($urandom);
            a1 = 8'($urandom); b1 = 8'($urandom); s1 = 3'($urandom);
            bus.A0 = a0; bus.B0 = b0; bus.Sel0 = s0;
            bus.A1 = a1; bus.B1 = b1; bus.Sel1 = s1;
            bus.req0 = m[0]; bus.req1 = m[1];
            w = (m == 3) ? ~model_last : (m == 2);
            exp_q.push_back(w ? expect_entry(1'b1, a1, b1, s1) : expect_entry(1'b0, a0, b0, s0));
            wait_gnt(ok);
            bus.req0 = 1'b0; bus.req1 = 1'b0;
            model_last = w;
            n_cmp++;
            if (!ok || bus.gnt0 !== ~w || bus.gnt1 !== w) begin
                n_bad++;
                $display("FAIL b2b_gnt op %0d: gnt0=%b gnt1=%b, required port %b", k, bus.gnt0, bus.gnt1, w);
            end
            step();
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.valid !== 1'b1 || bus.y !== e[7:0] || bus.id !== e[8]) begin
                n_bad++;
                $display("FAIL b2b_result op %0d: valid=%b y=%h id=%b, required valid=1 y=%h id=%b",
                         k, bus.valid, bus.y, bus.id, e[7:0], e[8]);
            end
            step();
        end
        bus.ack = 1'b0;
        n_cmp++;
        if (bus.valid !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_drain: valid=%b, required 0", bus.valid);
        end
    endtask

`ifdef ALU_ARB_FLAGS_EN
    task automatic test_flags();
        bit ok;
        logic [7:0] fa [2] = '{8'h01, 8'hFF};
        logic [7:0] fb [2] = '{8'h02, 8'h01};
        logic [2:0] fs [2] = '{OP_SUB, OP_ADD};
        logic [7:0] fy [2] = '{8'hFF, 8'h00};
        logic       fz [2] = '{1'b0, 1'b1};
        for (int k = 0; k < 2; k++) begin
            bus.A0 = fa[k]; bus.B0 = fb[k]; bus.Sel0 = fs[k]; bus.req0 = 1'b1;
            wait_gnt(ok);
            bus.req0 = 1'b0;
            model_last = 1'b0;
            wait_valid(ok);
            n_cmp++;
            if (!ok || bus.y !== fy[k] || bus.cf !== 1'b1 || bus.zf !== fz[k]) begin
                n_bad++;
                $display("FAIL flags case %0d: y=%h cf=%b zf=%b, required y=%h cf=1 zf=%b",
                         k, bus.y, bus.cf, bus.zf, fy[k], fz[k]);
            end
            ack_it();
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.req0 = 1'b0; bus.A0 = '0; bus.B0 = '0; bus.Sel0 = '0;
        bus.req1 = 1'b0; bus.A1 = '0; bus.B1 = '0; bus.Sel1 = '0;
        bus.ack = 1'b0;
        bus_fp.req0 = 1'b0; bus_fp.A0 = '0; bus_fp.B0 = '0; bus_fp.Sel0 = '0;
        bus_fp.req1 = 1'b0; bus_fp.A1 = '0; bus_fp.B1 = '0; bus_fp.Sel1 = '0;
        bus_fp.ack = 1'b0;
        model_last = 1'b1;

        test_reset();
        test_single_op();
        test_contention();
        test_fixed_prio();
        test_backpressure();
        test_mid_reset();
        test_back_to_back();
`ifdef ALU_ARB_FLAGS_EN
        test_flags();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
